// File: rtl/sdram_frame_arbiter_pkg.sv
// Shared definitions for the SDRAM frame-buffer arbiter: FSM state encoding,
// triple-buffer index constants and width helpers.
package sdram_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } arbState_e;

    localparam logic [1:0] BUF0 = 2'd0;
    localparam logic [1:0] BUF1 = 2'd1;
    localparam logic [1:0] BUF2 = 2'd2;

    // The three buffer indices sum to this, so the buffer that is neither of
    // two distinct indices a and b is BUF_SUM - a - b.
    localparam logic [1:0] BUF_SUM = BUF0 + BUF1 + BUF2;

    // The reader starts on the buffer the writer will reach last.
    localparam logic [1:0] RD_BUF_INIT = BUF2;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Width of an index over count items, never narrower than one bit.
    function automatic int indexWidth(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Burst command channel between the frame arbiter (master) and the SDRAM
// burst controller (slave).
interface sdram_frame_arbiter_if
    import sdram_frame_arbiter_pkg::*;
#(
    parameter int NPAIR  = 2,
    parameter int ADDR_W = 24
);

    localparam int PAIR_W = indexWidth(NPAIR);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [PAIR_W-1:0] cmd_pair;
    logic [ADDR_W-1:0] cmd_addr;
    logic              burst_done;

    modport master (
        output cmd_valid,
        output cmd_wr,
        output cmd_pair,
        output cmd_addr,
        input  cmd_ready,
        input  burst_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_wr,
        input  cmd_pair,
        input  cmd_addr,
        output cmd_ready,
        output burst_done
    );

endinterface

// File: rtl/sdram_frame_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting index at or after the
// pointer, wrapping around to the lowest requester when none lies above it.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] upperIdx;
    logic         upperFound;

    // Scan downwards so the last hit is the lowest index; prefer indices at or above the pointer.
    always_comb begin
        idx_o      = '0;
        found_o    = 1'b0;
        upperIdx   = '0;
        upperFound = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = W'(i);
                if (W'(i) >= ptr_i) begin
                    upperFound = 1'b1;
                    upperIdx   = W'(i);
                end
            end
        end
        if (upperFound) begin
            idx_o = upperIdx;
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// N-pair triple-buffered frame arbiter: grants one fixed-length SDRAM burst at
// a time (writes before reads), and keeps per-pair offsets and buffer indices
// so a reader never sees a half-written frame.
module sdram_frame_arbiter
    import sdram_frame_arbiter_pkg::*;
#(
    parameter int NPAIR       = 2,
    parameter int BURST       = 256,
    parameter int USEDW_W     = 11,
    parameter int RD_LOW      = 512,
    parameter int FRAME_WORDS = 307200,
    parameter int BUF_WORDS   = 524288,
    parameter int ADDR_W      = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPAIR*USEDW_W-1:0]   wr_usedw_i,
    input  logic [NPAIR*USEDW_W-1:0]   rd_usedw_i,
    input  logic [NPAIR-1:0]           wr_frame_start_i,
    input  logic [NPAIR-1:0]           rd_frame_start_i,
    sdram_frame_arbiter_if.master      cmd_if,
    output logic [2*NPAIR-1:0]         wr_buf_o,
    output logic [2*NPAIR-1:0]         rd_buf_o,
    output logic [NPAIR-1:0]           frame_valid_o
);

    localparam int                PAIR_W    = indexWidth(NPAIR);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
    localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NPAIR - 1);

    arbState_e         state_q, state_d;
    logic              cmdValid_q, cmdValid_d;
    logic              cmdWr_q, cmdWr_d;
    logic [PAIR_W-1:0] cmdPair_q, cmdPair_d;
    logic [ADDR_W-1:0] cmdAddr_q, cmdAddr_d;
    logic [PAIR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PAIR_W-1:0] rdPtr_q, rdPtr_d;
    logic              cancel_q, cancel_d;

    logic [ADDR_W-1:0] wrOff_q [NPAIR];
    logic [ADDR_W-1:0] wrOff_d [NPAIR];
    logic [ADDR_W-1:0] rdOff_q [NPAIR];
    logic [ADDR_W-1:0] rdOff_d [NPAIR];
    logic [1:0]        wrBuf_q [NPAIR];
    logic [1:0]        wrBuf_d [NPAIR];
    logic [1:0]        rdBuf_q [NPAIR];
    logic [1:0]        rdBuf_d [NPAIR];
    logic [1:0]        lastDone_q [NPAIR];
    logic [1:0]        lastDone_d [NPAIR];
    logic [NPAIR-1:0]  frameValid_q, frameValid_d;

    logic [NPAIR-1:0]  wrEligible, rdEligible;
    logic [PAIR_W-1:0] wrPick, rdPick;
    logic              wrFound, rdFound;
    logic              grantStart;
    logic              doneAdvance;

    // Start word of a burst inside pair's buffer region.
    function automatic logic [ADDR_W-1:0] burstAddr(input logic [PAIR_W-1:0] pair,
                                                    input logic [1:0]        bufIdx,
                                                    input logic [ADDR_W-1:0] offset);
        logic [ADDR_W-1:0] region;
        region = ADDR_W'((3 * 32'(pair) + 32'(bufIdx)) * 32'(BUF_WORDS));
        return region + offset;
    endfunction

    // Round-robin pointer moves just past the granted pair.
    function automatic logic [PAIR_W-1:0] nextPtr(input logic [PAIR_W-1:0] idx);
        return (idx == LAST_PAIR) ? '0 : idx + 1'b1;
    endfunction

    // Per-pair eligibility from FIFO fill levels and frame availability.
    always_comb begin
        wrEligible = '0;
        rdEligible = '0;
        for (int p = 0; p < NPAIR; p++) begin
            wrEligible[p] = 32'(wr_usedw_i[p*USEDW_W +: USEDW_W]) >= 32'(BURST);
            rdEligible[p] = frameValid_q[p] &&
                            (32'(rd_usedw_i[p*USEDW_W +: USEDW_W]) < 32'(RD_LOW));
        end
    end

    rr_pick #(.N(NPAIR), .W(PAIR_W)) u_wrPick (
        .req_i   (wrEligible),
        .ptr_i   (wrPtr_q),
        .idx_o   (wrPick),
        .found_o (wrFound)
    );

    rr_pick #(.N(NPAIR), .W(PAIR_W)) u_rdPick (
        .req_i   (rdEligible),
        .ptr_i   (rdPtr_q),
        .idx_o   (rdPick),
        .found_o (rdFound)
    );

    // A frame_start on the channel that owns the in-flight grant voids the offset advance.
    always_comb begin
        grantStart  = cmdWr_q ? wr_frame_start_i[cmdPair_q] : rd_frame_start_i[cmdPair_q];
        doneAdvance = (state_q == BUSY) && cmd_if.burst_done && !cancel_q && !grantStart;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wrFound || rdFound) state_d = REQ;
            REQ:     if (cmd_if.cmd_ready)   state_d = BUSY;
            BUSY:    if (cmd_if.burst_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: latch the grant in IDLE and release cmd_valid once accepted.
    always_comb begin
        cmdValid_d = cmdValid_q;
        cmdWr_d    = cmdWr_q;
        cmdPair_d  = cmdPair_q;
        cmdAddr_d  = cmdAddr_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        cancel_d   = cancel_q;
        case (state_q)
            IDLE: begin
                if (wrFound) begin
                    cmdValid_d = 1'b1;
                    cmdWr_d    = 1'b1;
                    cmdPair_d  = wrPick;
                    cmdAddr_d  = burstAddr(wrPick, wrBuf_q[wrPick], wrOff_d[wrPick]);
                    wrPtr_d    = nextPtr(wrPick);
                    cancel_d   = 1'b0;
                end else if (rdFound) begin
                    cmdValid_d = 1'b1;
                    cmdWr_d    = 1'b0;
                    cmdPair_d  = rdPick;
                    cmdAddr_d  = burstAddr(rdPick, rdBuf_d[rdPick], rdOff_d[rdPick]);
                    rdPtr_d    = nextPtr(rdPick);
                    cancel_d   = 1'b0;
                end
            end
            REQ: begin
                if (cmd_if.cmd_ready) begin
                    cmdValid_d = 1'b0;
                end
                cancel_d = cancel_q || grantStart;
            end
            BUSY: begin
                cancel_d = cancel_q || grantStart;
            end
            default: begin
                cmdValid_d = 1'b0;
            end
        endcase
    end

    // Registered command outputs and round-robin pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdValid_q <= 1'b0;
            cmdWr_q    <= 1'b0;
            cmdPair_q  <= '0;
            cmdAddr_q  <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            cancel_q   <= 1'b0;
        end else begin
            cmdValid_q <= cmdValid_d;
            cmdWr_q    <= cmdWr_d;
            cmdPair_q  <= cmdPair_d;
            cmdAddr_q  <= cmdAddr_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            cancel_q   <= cancel_d;
        end
    end

    // Per-pair offsets and buffer rotation; frame starts apply first, then burst completion.
    always_comb begin
        for (int p = 0; p < NPAIR; p++) begin
            wrOff_d[p]      = wr_frame_start_i[p] ? '0 : wrOff_q[p];
            rdOff_d[p]      = rd_frame_start_i[p] ? '0 : rdOff_q[p];
            rdBuf_d[p]      = (rd_frame_start_i[p] && frameValid_q[p]) ? lastDone_q[p] : rdBuf_q[p];
            wrBuf_d[p]      = wrBuf_q[p];
            lastDone_d[p]   = lastDone_q[p];
            frameValid_d[p] = frameValid_q[p];
            if (doneAdvance && (PAIR_W'(p) == cmdPair_q)) begin
                if (cmdWr_q) begin
                    if (wrOff_q[p] + BURST_A >= FRAME_A) begin
                        wrOff_d[p]      = '0;
                        lastDone_d[p]   = wrBuf_q[p];
                        frameValid_d[p] = 1'b1;
                        wrBuf_d[p]      = BUF_SUM - wrBuf_q[p] - rdBuf_d[p];
                    end else begin
                        wrOff_d[p] = wrOff_q[p] + BURST_A;
                    end
                end else begin
                    rdOff_d[p] = (rdOff_q[p] + BURST_A >= FRAME_A) ? '0 : rdOff_q[p] + BURST_A;
                end
            end
        end
    end

    // Per-pair state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPAIR; p++) begin
                wrOff_q[p]    <= '0;
                rdOff_q[p]    <= '0;
                wrBuf_q[p]    <= BUF0;
                rdBuf_q[p]    <= RD_BUF_INIT;
                lastDone_q[p] <= BUF0;
            end
            frameValid_q <= '0;
        end else begin
            for (int p = 0; p < NPAIR; p++) begin
                wrOff_q[p]    <= wrOff_d[p];
                rdOff_q[p]    <= rdOff_d[p];
                wrBuf_q[p]    <= wrBuf_d[p];
                rdBuf_q[p]    <= rdBuf_d[p];
                lastDone_q[p] <= lastDone_d[p];
            end
            frameValid_q <= frameValid_d;
        end
    end

    // Flatten per-pair buffer indices onto the output buses.
    always_comb begin
        wr_buf_o = '0;
        rd_buf_o = '0;
        for (int p = 0; p < NPAIR; p++) begin
            wr_buf_o[2*p +: 2] = wrBuf_q[p];
            rd_buf_o[2*p +: 2] = rdBuf_q[p];
        end
    end

    assign frame_valid_o     = frameValid_q;
    assign cmd_if.cmd_valid  = cmdValid_q;
    assign cmd_if.cmd_wr     = cmdWr_q;
    assign cmd_if.cmd_pair   = cmdPair_q;
    assign cmd_if.cmd_addr   = cmdAddr_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed testbench for sdram_frame_arbiter with two pairs and a small
// 1024-word frame / 2048-word buffer geometry.
module tb_sdram_frame_arbiter;

    localparam int NPAIR       = 2;
    localparam int BURST       = 256;
    localparam int USEDW_W     = 11;
    localparam int RD_LOW      = 512;
    localparam int FRAME_WORDS = 1024;
    localparam int BUF_WORDS   = 2048;
    localparam int ADDR_W      = 24;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NPAIR*USEDW_W-1:0] wrUsedw = '0;
    logic [NPAIR*USEDW_W-1:0] rdUsedw = '0;
    logic [NPAIR-1:0]         wrFrameStart = '0;
    logic [NPAIR-1:0]         rdFrameStart = '0;
    logic [2*NPAIR-1:0]       wrBuf;
    logic [2*NPAIR-1:0]       rdBuf;
    logic [NPAIR-1:0]         frameValid;

    int compareCount  = 0;
    int mismatchCount = 0;

    sdram_frame_arbiter_if #(.NPAIR(NPAIR), .ADDR_W(ADDR_W)) cmdIf ();

    sdram_frame_arbiter #(
        .NPAIR       (NPAIR),
        .BURST       (BURST),
        .USEDW_W     (USEDW_W),
        .RD_LOW      (RD_LOW),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF_WORDS   (BUF_WORDS),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_usedw_i       (wrUsedw),
        .rd_usedw_i       (rdUsedw),
        .wr_frame_start_i (wrFrameStart),
        .rd_frame_start_i (rdFrameStart),
        .cmd_if           (cmdIf),
        .wr_buf_o         (wrBuf),
        .rd_buf_o         (rdBuf),
        .frame_valid_o    (frameValid)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int wu0, input int wu1, input int ru0, input int ru1);
        wrUsedw = {USEDW_W'(wu1), USEDW_W'(wu0)};
        rdUsedw = {USEDW_W'(ru1), USEDW_W'(ru0)};
    endtask

    task automatic doReset();
        rst               = 1'b1;
        cmdIf.cmd_ready   = 1'b0;
        cmdIf.burst_done  = 1'b0;
        wrFrameStart      = '0;
        rdFrameStart      = '0;
        applyStimulus(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkCmd(input string tag, input logic expWr, input int expPair, input int expAddr);
        checkOutput({tag, "_wr"},   32'(cmdIf.cmd_wr),   32'(expWr));
        checkOutput({tag, "_pair"}, 32'(cmdIf.cmd_pair), 32'(expPair));
        checkOutput({tag, "_addr"}, 32'(cmdIf.cmd_addr), 32'(expAddr));
    endtask

    task automatic waitCmd(output bit found);
        int n;
        n = 0;
        while (cmdIf.cmd_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        found = (cmdIf.cmd_valid === 1'b1);
        if (!found) checkOutput("cmdTimeout", 32'(found), 1);
    endtask

    // startMode: 0 none, 1 wr_frame_start during BUSY, 2 wr_frame_start with burst_done.
    task automatic expectBurst(input string tag, input logic expWr, input int expPair, input int expAddr,
                               input int readyDelay, input int startMode);
        bit found;
        waitCmd(found);
        if (!found) return;
        checkCmd(tag, expWr, expPair, expAddr);
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput({tag, "_holdValid"}, 32'(cmdIf.cmd_valid), 1);
            checkCmd({tag, "_hold"}, expWr, expPair, expAddr);
        end
        cmdIf.cmd_ready = 1'b1;
        @(negedge clk);
        cmdIf.cmd_ready = 1'b0;
        checkOutput({tag, "_validDrop"}, 32'(cmdIf.cmd_valid), 0);
        if (startMode == 1) wrFrameStart[expPair] = 1'b1;
        @(negedge clk);
        wrFrameStart     = '0;
        cmdIf.burst_done = 1'b1;
        if (startMode == 2) wrFrameStart[expPair] = 1'b1;
        @(negedge clk);
        cmdIf.burst_done = 1'b0;
        wrFrameStart     = '0;
        checkOutput({tag, "_bufNeq0"}, 32'(wrBuf[1:0] != rdBuf[1:0]), 1);
        checkOutput({tag, "_bufNeq1"}, 32'(wrBuf[3:2] != rdBuf[3:2]), 1);
    endtask

    // Main directed sequence.
    initial begin
        bit found;
        int validSeen;

        cmdIf.cmd_ready  = 1'b0;
        cmdIf.burst_done = 1'b0;

        // Reset values and quiet idle.
        doReset();
        checkOutput("rst_valid", 32'(cmdIf.cmd_valid), 0);
        checkCmd("rst", 1'b0, 0, 0);
        checkOutput("rst_wrBuf", 32'(wrBuf), 32'h0);
        checkOutput("rst_rdBuf", 32'(rdBuf), 32'hA);
        checkOutput("rst_frameValid", 32'(frameValid), 0);
        validSeen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmdIf.cmd_valid === 1'b1) validSeen++;
        end
        checkOutput("idle_noCmd", 32'(validSeen), 0);

        // Single write channel, held-off ready, then reset mid-request.
        applyStimulus(256, 0, 0, 0);
        @(negedge clk);
        checkOutput("s2_latency", 32'(cmdIf.cmd_valid), 1);
        expectBurst("s2_w0a", 1'b1, 0, 0, 5, 0);
        waitCmd(found);
        if (found) checkCmd("s2_w0b", 1'b1, 0, 256);
        rst = 1'b1;
        #1;
        checkOutput("s2_rstValid", 32'(cmdIf.cmd_valid), 0);
        checkCmd("s2_rst", 1'b0, 0, 0);

        // Full frame on pair 1 rotates its write buffer.
        doReset();
        applyStimulus(0, 256, 0, 0);
        expectBurst("s3_b0", 1'b1, 1, 6144, 0, 0);
        expectBurst("s3_b1", 1'b1, 1, 6400, 0, 0);
        expectBurst("s3_b2", 1'b1, 1, 6656, 0, 0);
        expectBurst("s3_b3", 1'b1, 1, 6912, 0, 0);
        checkOutput("s3_wrBuf", 32'(wrBuf), 32'h4);
        checkOutput("s3_rdBuf", 32'(rdBuf), 32'hA);
        checkOutput("s3_frameValid", 32'(frameValid), 32'h2);
        expectBurst("s3_next", 1'b1, 1, 8192, 0, 0);

        // Write round-robin, write priority over reads, read round-robin.
        doReset();
        applyStimulus(256, 256, 0, 0);
        for (int k = 0; k < 4; k++) begin
            expectBurst($sformatf("s4_w0_%0d", k), 1'b1, 0, k * 256, 0, 0);
            expectBurst($sformatf("s4_w1_%0d", k), 1'b1, 1, 6144 + k * 256, 0, 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("s4_frameValid", 32'(frameValid), 32'h3);
        checkOutput("s4_wrBuf", 32'(wrBuf), 32'h5);
        expectBurst("s4_r0", 1'b0, 0, 4096, 0, 0);
        expectBurst("s4_r1", 1'b0, 1, 10240, 0, 0);
        applyStimulus(0, 256, 0, 0);
        expectBurst("s4_wPrio", 1'b1, 1, 8192, 0, 0);
        applyStimulus(0, 0, 0, 0);
        expectBurst("s4_r0b", 1'b0, 0, 4352, 0, 0);

        // Reader switches to the completed buffer; writer avoids both.
        doReset();
        applyStimulus(256, 0, 600, 600);
        for (int k = 0; k < 4; k++) begin
            expectBurst($sformatf("s5_w_%0d", k), 1'b1, 0, k * 256, 0, 0);
        end
        applyStimulus(0, 0, 600, 600);
        checkOutput("s5_wrBuf0", 32'(wrBuf[1:0]), 1);
        checkOutput("s5_rdBuf0", 32'(rdBuf[1:0]), 2);
        checkOutput("s5_frameValid", 32'(frameValid), 1);
        rdFrameStart[0] = 1'b1;
        @(negedge clk);
        rdFrameStart = '0;
        checkOutput("s5_rdBufSwap", 32'(rdBuf[1:0]), 0);
        checkOutput("s5_neqSwap", 32'(wrBuf[1:0] != rdBuf[1:0]), 1);
        applyStimulus(0, 0, 0, 600);
        expectBurst("s5_r0", 1'b0, 0, 0, 0, 0);
        expectBurst("s5_r1", 1'b0, 0, 256, 0, 0);
        applyStimulus(256, 0, 600, 600);
        for (int k = 0; k < 4; k++) begin
            expectBurst($sformatf("s5_w2_%0d", k), 1'b1, 0, 2048 + k * 256, 0, 0);
        end
        applyStimulus(0, 0, 600, 600);
        checkOutput("s5_wrBuf0b", 32'(wrBuf[1:0]), 2);
        checkOutput("s5_rdBuf0b", 32'(rdBuf[1:0]), 0);

        // Write frame restart mid-frame, and frame_start racing burst completion.
        doReset();
        applyStimulus(256, 0, 600, 600);
        expectBurst("s6_a", 1'b1, 0, 0, 0, 0);
        expectBurst("s6_b", 1'b1, 0, 256, 0, 0);
        applyStimulus(0, 0, 600, 600);
        @(negedge clk);
        @(negedge clk);
        wrFrameStart[0] = 1'b1;
        @(negedge clk);
        wrFrameStart = '0;
        checkOutput("s6_frameValid", 32'(frameValid), 0);
        applyStimulus(256, 0, 600, 600);
        expectBurst("s6_restart", 1'b1, 0, 0, 0, 0);
        expectBurst("s6_sameCycle", 1'b1, 0, 256, 0, 2);
        expectBurst("s6_afterSame", 1'b1, 0, 0, 0, 1);
        expectBurst("s6_afterBusy", 1'b1, 0, 0, 0, 0);
        waitCmd(found);
        if (found) checkCmd("s6_final", 1'b1, 0, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sdram_frame_arbiter.md
# sdram_frame_arbiter

Parametrised N-pair frame-buffer arbiter between the camera-side write FIFOs, the display-side read FIFOs and the SDRAM burst controller. It generalises the fixed one-writer/one-reader SDRAM port scheme to NPAIR write/read channel pairs. Each pair gets its own triple-buffered frame region, so the reader never sees a half-written frame. The block issues one fixed-length burst command at a time and tracks per-channel address offsets and buffer indices.

## Interface
- NPAIR, 2, number of write/read channel pairs
- BURST, 256, words per SDRAM burst; power of two
- USEDW_W, 11, width of each FIFO fill count
- RD_LOW, 512, read FIFO refill threshold
- FRAME_WORDS, 307200, words per frame; multiple of BURST
- BUF_WORDS, 524288, words per buffer; must be ≥ FRAME_WORDS
- ADDR_W, 24, SDRAM word-address width; must hold 3·NPAIR·BUF_WORDS
- clk  in  1  single clock, shared with the SDRAM controller
- rst  in  1  reset, asynchronous, active-high
- wr_usedw  in  NPAIR·USEDW_W  per-pair write FIFO fill (read side)
- rd_usedw  in  NPAIR·USEDW_W  per-pair read FIFO fill (write side)
- wr_frame_start  in  NPAIR  one-cycle pulse: camera frame start
- rd_frame_start  in  NPAIR  one-cycle pulse: display frame start
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  controller accepts the command
- cmd_wr  out  1  1 = write burst, 0 = read burst
- cmd_pair  out  max(1,clog2(NPAIR))  pair index
- cmd_addr  out  ADDR_W  burst start word address
- burst_done  in  1  one-cycle pulse: granted burst finished
- wr_buf, rd_buf  out  2·NPAIR  per-pair buffer index (0..2)
- frame_valid  out  NPAIR  pair has at least one completed frame

## Operation
- FSM states: IDLE, REQ, BUSY.
  - IDLE: choose a grant, or stay in IDLE if nothing is eligible.
  - REQ: hold cmd_valid until cmd_ready.
  - BUSY: wait for burst_done, then return to IDLE.
- Write channel p is eligible when wr_usedw[p] ≥ BURST.
- Read channel p is eligible when frame_valid[p] = 1 and rd_usedw[p] < RD_LOW.
- Writes have strict priority over reads, because the camera cannot stall.
  - Within writes: round-robin; the pointer moves past the granted pair.
  - Within reads: separate round-robin, same rule.
- Address: cmd_addr = (3·p + buf)·BUF_WORDS + offset.
  - buf is wr_buf[p] or rd_buf[p] according to direction.
- On burst_done, the granted channel's offset advances by BURST.
- Write offset reaching FRAME_WORDS:
  - offset resets to 0;
  - last_done[p] takes the old wr_buf[p];
  - frame_valid[p] is set;
  - wr_buf[p] becomes 3 − old wr_buf − rd_buf, the buffer that is neither the one just completed nor the one being read.
- Read offset reaching FRAME_WORDS: wraps to 0 on the same buffer, so the frame repeats.
- rd_frame_start[p]: read offset becomes 0; if frame_valid[p], rd_buf[p] takes last_done[p].
- wr_frame_start[p]: write offset becomes 0; no buffer toggle; the partial frame is discarded.
- Invariant: wr_buf[p] ≠ rd_buf[p] at all times.

## Timing
- Reset values:
  - cmd_valid = 0, cmd_wr = 0, cmd_pair = 0, cmd_addr = 0;
  - wr_buf = 0 and rd_buf = 2 for every pair;
  - frame_valid = 0; all offsets and round-robin pointers = 0; FSM in IDLE.
- Command outputs are registered.
  - cmd_valid rises the cycle after IDLE sees an eligible channel.
  - cmd_wr, cmd_pair and cmd_addr stay stable while cmd_valid = 1.
  - cmd_valid falls the cycle after cmd_valid && cmd_ready.
- burst_done is honoured only in BUSY; elsewhere it is ignored.
  - BUSY → IDLE on the cycle after burst_done.
  - Offset and buffer updates take effect on that same edge.
- Minimum gap from burst_done to the next cmd_valid: 2 cycles.
- A frame_start pulse on the same cycle as burst_done for the same channel: frame_start wins; the offset goes to 0 and is not advanced.
- A frame_start pulse while that channel's burst is in REQ or BUSY: the grant completes with its latched address, and the completion does not advance the offset.
- Asserting rst mid-burst returns every output to its reset value immediately; the controller side is reset together.

## Structure
- Shared include holds:
  - FSM state encodings;
  - buffer-index constants BUF0..BUF2 and the initial rd_buf value;
  - a clog2 function.
- Sub-module rr_pick: N-bit request vector plus pointer in, index and found flag out. It is instantiated twice, once for writes and once for reads.

## Test plan
All scenarios use NPAIR = 2, BURST = 256, FRAME_WORDS = 1024, BUF_WORDS = 2048, RD_LOW = 512.
- Reset, all usedw = 0 → all outputs at reset values; no cmd_valid for 100 cycles.
- wr_usedw[0] = 256, cmd_ready held low 5 cycles → cmd_wr = 1, cmd_pair = 0, cmd_addr = 0, all stable; after burst_done, the next write command has addr 256.
- Four write bursts on pair 1 → addrs 6144, 6400, 6656, 6912; then wr_buf[1] = 1 and frame_valid[1] = 1; the next write goes to 8192.
- Both writes and both reads eligible → grant order w0, w1, w0, …; a read is granted only when both wr_usedw < 256.
- Pair 0 completes buf 0, then rd_frame_start[0] → rd_buf[0] = 0 and reads start at addr 0; the next completion moves wr_buf[0] from 1 to 2; check wr_buf ≠ rd_buf after every update.
- wr_frame_start[0] mid-frame (offset 512) → next write addr 0 on the same buffer; frame_valid unchanged; same-cycle frame_start and burst_done → offset 0.
